mem_responder: RTL

Multicycle memory responder at the far end of the controller's memory interface. It accepts a word read or write strobe, applies a programmable number of wait states, then completes the access against an internal word RAM. It signals completion with a one-cycle `ready` pulse, with `err` raised for illegal accesses. It sits between the datapath's address/write-data mux and the instruction/data register loads, so the controller can run against slow memory models.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_word_ram.sv | 53 +++++
 rtl/mem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the multicycle memory responder.
//   mem_state_t     : responder FSM state, 2-bit encoding
//   WORD_BYTES      : bytes per RAM word
//   OFFSET_W        : byte-offset bits inside a word
//   ALIGN_MASK      : byte-offset bits that must be zero for a word access
//   access_illegal(): classifies a request as illegal (no RAM access)
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10,
        ERR  = 2'b11
    } mem_state_t;

    localparam int         WORD_BYTES = 4;
    localparam int         OFFSET_W   = $clog2(WORD_BYTES);
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // A request is illegal when both strobes are high, the byte address is
    // not word aligned, or any address bit above the RAM index is set.
    function automatic logic access_illegal(
        input logic        rd,
        input logic        wr,
        input logic [31:0] byte_addr,
        input int          addr_w
    );
        logic both_s;
        logic misaligned_s;
        logic out_of_range_s;
        both_s         = rd & wr;
        misaligned_s   = (byte_addr[1:0] & ALIGN_MASK) != 2'b00;
        out_of_range_s = (byte_addr >> (addr_w + OFFSET_W)) != 32'd0;
        return both_s | misaligned_s | out_of_range_s;
    endfunction

endpackage

// File: rtl/mem_word_ram.sv
// ---------------------------------------------------------------------------
// mem_word_ram
// Single-port word RAM, 2^ADDR_W x DATA_W, with a synchronous write enable
// and a synchronous read into an output register. The array itself is not
// reset; only the read register is cleared by rst_n.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (read register only)
//   we     in   write enable, RAM[addr] <= wdata on the rising edge
//   re     in   read enable, rdata <= RAM[addr] on the rising edge
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data, holds between reads
// ---------------------------------------------------------------------------
module mem_word_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage array: contents survive reset, written only on we.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register: loaded only on re, otherwise holds the last read word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Multicycle memory responder. Accepts a word read or write strobe in IDLE,
// inserts WAIT_CYCLES wait states, then completes the access against an
// internal word RAM and pulses ready for one cycle. Illegal requests skip
// the RAM and pulse ready together with err one cycle after acceptance.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mem_read   in   read request strobe
//   mem_write  in   write request strobe
//   addr       in   byte address
//   wdata      in   write data
//   rdata      out  registered read data, changes only on a successful read
//   ready      out  registered one-cycle completion pulse
//   err        out  registered one-cycle error pulse, coincident with ready
// ---------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int             CNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    mem_state_t        state_r;
    mem_state_t        state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] idx_r;
    logic [31:0]       wdata_r;
    logic              write_r;
    logic              ready_r;
    logic              err_r;

    logic              req_s;
    logic              illegal_s;
    logic              acc_write_s;
    logic [ADDR_W-1:0] acc_idx_s;
    logic [31:0]       acc_wdata_s;
    logic              ram_we_s;
    logic              ram_re_s;
    logic              ready_next_s;
    logic              err_next_s;
    logic [31:0]       ram_rdata_s;

    assign req_s     = mem_read | mem_write;
    assign illegal_s = access_illegal(mem_read, mem_write, addr, ADDR_W);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!req_s) begin
                    state_next_s = IDLE;
                end else if (illegal_s) begin
                    state_next_s = ERR;
                end else if (WAIT_CYCLES == 32'sd0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ONE) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            ERR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Access operands: with zero wait states the RAM is touched on the same
    // edge that accepts the request, so the live inputs must be used there;
    // from WAIT the latched request is used.
    always_comb begin
        if (state_r == IDLE) begin
            acc_write_s = mem_write;
            acc_idx_s   = addr[ADDR_W+OFFSET_W-1:OFFSET_W];
            acc_wdata_s = wdata;
        end else begin
            acc_write_s = write_r;
            acc_idx_s   = idx_r;
            acc_wdata_s = wdata_r;
        end
    end

    // FSM outputs: RAM strobes on the edge entering RESP, next ready/err.
    // The RAM strobes are gated by rst_n so no access can slip through while
    // reset is held with a strobe still asserted.
    always_comb begin
        ram_we_s     = 1'b0;
        ram_re_s     = 1'b0;
        ready_next_s = 1'b0;
        err_next_s   = 1'b0;
        case (state_next_s)
            RESP: begin
                ram_we_s     = rst_n & acc_write_s;
                ram_re_s     = rst_n & ~acc_write_s;
                ready_next_s = 1'b1;
                err_next_s   = 1'b0;
            end
            ERR: begin
                ready_next_s = 1'b1;
                err_next_s   = 1'b1;
            end
            default: begin
                ready_next_s = 1'b0;
                err_next_s   = 1'b0;
            end
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= CNT_ZERO;
            idx_r   <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            write_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        cnt_r   <= CNT_LOAD;
                        idx_r   <= addr[ADDR_W+OFFSET_W-1:OFFSET_W];
                        wdata_r <= wdata;
                        write_r <= mem_write;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - CNT_ONE;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered completion and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= ready_next_s;
            err_r   <= err_next_s;
        end
    end

    mem_word_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (acc_idx_s),
        .wdata (acc_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign rdata = ram_rdata_s;
    assign ready = ready_r;
    assign err   = err_r;

endmodule
